// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU arbiter slice.
//   - ALU opcode constants (ALU_ADD..ALU_XOR, ALU_OP_MAX)
//   - state_t: arbiter FSM state encoding (IDLE / EXEC)
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_OP_MAX = 4'd4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu.sv
// alu: combinational DATAPATH_WIDTH-bit ALU.
// Ports:
//   a, b    in  operands
//   ctrl    in  4-bit opcode (add, sub, and, or, xor); other opcodes give 0
//   result  out wrapped result, no carry/overflow
module alu
    import alu_pkg::*;
#(
    parameter int DATAPATH_WIDTH = 64
) (
    input  logic [DATAPATH_WIDTH-1:0] a,
    input  logic [DATAPATH_WIDTH-1:0] b,
    input  logic [3:0]                ctrl,
    output logic [DATAPATH_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports:
//   req       in  request vector
//   rr_ptr    in  highest-priority index for this round
//   grant     out one-hot grant (all zero when no request)
//   grant_id  out encoded index of the granted requester
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    logic        found;
    int unsigned idx;

    // Walk the requesters starting at rr_ptr, wrapping modulo NUM_REQ;
    // the first active one wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NUM_REQ requesters.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req_in            per-requester request level
//   a_in, b_in        packed operands, requester i at [i*W +: W]
//   ctrl_in           packed opcodes, requester i at [i*4 +: 4]
//   grant_out         one-hot pulse: winner's operands captured
//   result_out        registered ALU result (holds between results)
//   result_valid_out  pulse: result_out / result_id_out valid
//   result_id_out     requester owning result_out
//   op_err_out        pulses with result_valid_out for opcodes > ALU_OP_MAX
//   busy_out          high while executing
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATAPATH_WIDTH = 64,
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_in,
    input  logic [NUM_REQ*DATAPATH_WIDTH-1:0] a_in,
    input  logic [NUM_REQ*DATAPATH_WIDTH-1:0] b_in,
    input  logic [NUM_REQ*4-1:0]              ctrl_in,
    output logic [NUM_REQ-1:0]                grant_out,
    output logic [DATAPATH_WIDTH-1:0]         result_out,
    output logic                              result_valid_out,
    output logic [ID_WIDTH-1:0]               result_id_out,
    output logic                              op_err_out,
    output logic                              busy_out
);

    state_t                    state_q, state_d;
    logic                      load, finish;
    logic [ID_WIDTH-1:0]       rr_ptr;
    logic [DATAPATH_WIDTH-1:0] op_a_q, op_b_q;
    logic [3:0]                ctrl_q;
    logic [ID_WIDTH-1:0]       id_q;

    logic [NUM_REQ-1:0]        arb_grant;
    logic [ID_WIDTH-1:0]       arb_id;
    logic [DATAPATH_WIDTH-1:0] sel_a, sel_b;
    logic [3:0]                sel_ctrl;
    logic [DATAPATH_WIDTH-1:0] alu_result;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req      (req_in),
        .rr_ptr   (rr_ptr),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    alu #(
        .DATAPATH_WIDTH (DATAPATH_WIDTH)
    ) u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .ctrl   (ctrl_q),
        .result (alu_result)
    );

    // One-hot mux of the winner's operand slices.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_a    = a_in[i*DATAPATH_WIDTH +: DATAPATH_WIDTH];
                sel_b    = b_in[i*DATAPATH_WIDTH +: DATAPATH_WIDTH];
                sel_ctrl = ctrl_in[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_in) begin
                    state_d = EXEC;
                    load    = 1'b1;
                end
            end
            EXEC: begin
                state_d = IDLE;
                finish  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr           <= '0;
            op_a_q           <= '0;
            op_b_q           <= '0;
            ctrl_q           <= '0;
            id_q             <= '0;
            grant_out        <= '0;
            result_out       <= '0;
            result_valid_out <= 1'b0;
            result_id_out    <= '0;
            op_err_out       <= 1'b0;
        end else begin
            grant_out        <= '0;
            result_valid_out <= 1'b0;
            op_err_out       <= 1'b0;
            if (load) begin
                op_a_q    <= sel_a;
                op_b_q    <= sel_b;
                ctrl_q    <= sel_ctrl;
                id_q      <= arb_id;
                grant_out <= arb_grant;
                rr_ptr    <= (arb_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
            end
            if (finish) begin
                result_out       <= alu_result;
                result_id_out    <= id_q;
                result_valid_out <= 1'b1;
                op_err_out       <= (ctrl_q > ALU_OP_MAX);
            end
        end
    end

    assign busy_out = (state_q == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_in;
    logic [255:0] a_in, b_in;
    logic [15:0]  ctrl_in;
    logic [3:0]   grant_out;
    logic [63:0]  result_out;
    logic         result_valid_out;
    logic [1:0]   result_id_out;
    logic         op_err_out;
    logic         busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(
        .DATAPATH_WIDTH (64),
        .NUM_REQ        (4),
        .ID_WIDTH       (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_in           (req_in),
        .a_in             (a_in),
        .b_in             (b_in),
        .ctrl_in          (ctrl_in),
        .grant_out        (grant_out),
        .result_out       (result_out),
        .result_valid_out (result_valid_out),
        .result_id_out    (result_id_out),
        .op_err_out       (op_err_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] c);
        a_in[i*64 +: 64] = a;
        b_in[i*64 +: 64] = b;
        ctrl_in[i*4 +: 4] = c;
        req_in[i] = 1'b1;
    endtask

    // Single isolated operation: grant, result, then result hold.
    task automatic do_op(input string tag, input int i, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] c,
                         input logic [63:0] exp_r, input logic exp_err);
        set_op(i, a, b, c);
        tick();
        check({tag, "_grant"}, grant_out, 64'(1) << i);
        check({tag, "_busy"}, busy_out, 1);
        check({tag, "_valid_early"}, result_valid_out, 0);
        req_in[i] = 1'b0;
        tick();
        check({tag, "_valid"}, result_valid_out, 1);
        check({tag, "_result"}, result_out, exp_r);
        check({tag, "_id"}, result_id_out, 64'(i));
        check({tag, "_err"}, op_err_out, exp_err);
        check({tag, "_busy_done"}, busy_out, 0);
        tick();
        check({tag, "_valid_drop"}, result_valid_out, 0);
        check({tag, "_err_drop"}, op_err_out, 0);
        check({tag, "_hold"}, result_out, exp_r);
    endtask

    initial begin
        reset   = 1'b1;
        req_in  = '0;
        a_in    = '0;
        b_in    = '0;
        ctrl_in = '0;
        tick();
        tick();
        check("rst_grant", grant_out, 0);
        check("rst_result", result_out, 0);
        check("rst_valid", result_valid_out, 0);
        check("rst_id", result_id_out, 0);
        check("rst_err", op_err_out, 0);
        check("rst_busy", busy_out, 0);
        reset = 1'b0;
        tick();
        check("idle_no_grant", grant_out, 0);

        // Single request on requester 1: 5 - 3.
        do_op("single", 1, 64'd5, 64'd3, 4'd1, 64'd2, 1'b0);

        // Round-robin from a fresh pointer with everyone requesting.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 64'(i), 64'd10, 4'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", grant_out, 64'(1) << (k % 4));
            check("rr_busy", busy_out, 1);
            tick();
            check("rr_valid", result_valid_out, 1);
            check("rr_id", result_id_out, 64'(k % 4));
            check("rr_result", result_out, 64'(10 + (k % 4)));
            check("rr_gap", grant_out, 0);
        end
        req_in = '0;
        tick();
        check("rr_stop", grant_out, 0);

        // Wrap arithmetic and remaining opcodes.
        do_op("add_wrap", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 64'd0, 1'b0);
        do_op("sub_wrap", 0, 64'd0, 64'd1, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_op("or_op", 1, 64'hF0, 64'h3C, 4'd3, 64'hFC, 1'b0);
        do_op("xor_op", 3, 64'hF0, 64'h3C, 4'd4, 64'hCC, 1'b0);
        do_op("illegal", 2, 64'd7, 64'd7, 4'd9, 64'd0, 1'b1);

        // Operand/opcode changes and a new request during EXEC are ignored.
        set_op(3, 64'hF0, 64'h3C, 4'd2);
        tick();
        check("stable_grant", grant_out, 64'h8);
        a_in[3*64 +: 64] = 64'hFF;
        ctrl_in[12 +: 4] = 4'd3;
        req_in[3] = 1'b0;
        set_op(0, 64'd1, 64'd1, 4'd0);
        tick();
        check("stable_result", result_out, 64'h30);
        check("stable_valid", result_valid_out, 1);
        check("stable_no_grant", grant_out, 0);
        tick();
        check("late_grant", grant_out, 64'h1);
        req_in[0] = 1'b0;
        tick();
        check("late_result", result_out, 64'd2);
        check("late_id", result_id_out, 0);

        // Reset during EXEC: requester 2 wins (pointer would advance to 3).
        set_op(2, 64'd1, 64'd1, 4'd0);
        tick();
        check("mid_busy", busy_out, 1);
        check("mid_grant", grant_out, 64'h4);
        req_in[2] = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_grant", grant_out, 0);
        check("mid_rst_result", result_out, 0);
        check("mid_rst_id", result_id_out, 0);
        check("mid_rst_valid", result_valid_out, 0);
        tick();
        check("mid_rst_hold_valid", result_valid_out, 0);
        reset = 1'b0;
        tick();
        check("mid_post_valid", result_valid_out, 0);
        set_op(0, 64'd4, 64'd4, 4'd0);
        set_op(3, 64'd9, 64'd2, 4'd1);
        tick();
        check("post_rst_ptr", grant_out, 64'h1);
        req_in[0] = 1'b0;
        tick();
        check("post_rst_result0", result_out, 64'd8);
        check("post_rst_id0", result_id_out, 0);
        tick();
        check("post_rst_grant3", grant_out, 64'h8);
        req_in[3] = 1'b0;
        tick();
        check("post_rst_result3", result_out, 64'd7);
        check("post_rst_id3", result_id_out, 64'd3);
        check("post_rst_valid3", result_valid_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 64-bit ALU datapath between NUM_REQ requesters (cores or thread contexts).
- Arbitrates round-robin, latches the winner's operands and opcode, and runs the ALU in a two-state FSM.
- Returns a registered result tagged with the requester index.
- Sits between the per-core issue stages and a single shared alu instance.

Parameters:
- DATAPATH_WIDTH, 64, operand/result width; passed to the alu instance.
- NUM_REQ, 4, number of requesters; must be ≥2.
- ID_WIDTH, 2, width of requester index; must satisfy 2**ID_WIDTH ≥ NUM_REQ.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_in  in  NUM_REQ  per-requester request level.
- a_in  in  NUM_REQ*DATAPATH_WIDTH  operand A; requester i occupies slice [i*W +: W].
- b_in  in  NUM_REQ*DATAPATH_WIDTH  operand B; same packing as a_in.
- ctrl_in  in  NUM_REQ*4  opcode; requester i occupies [i*4 +: 4].
- grant_out  out  NUM_REQ  one-hot, one-cycle pulse: operands captured.
- result_out  out  DATAPATH_WIDTH  registered ALU result.
- result_valid_out  out  1  one-cycle pulse: result_out and result_id_out valid.
- result_id_out  out  ID_WIDTH  index of the requester that owns result_out.
- op_err_out  out  1  pulses together with result_valid_out when the latched opcode > 4.
- busy_out  out  1  high while in EXEC.

Behaviour:
- Reset (async, immediate), all outputs 0:
  - state=IDLE; rr_ptr=0; grant_out=0; result_out=0; result_valid_out=0; result_id_out=0; op_err_out=0; busy_out=0.
  - Operand registers cleared.
- FSM states: IDLE, EXEC.
- IDLE, req_in == 0: stay in IDLE; grant_out=0.
- IDLE, req_in != 0, at the clock edge:
  - Winner = first set bit of req_in, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Latch winner's a/b/ctrl into op_a_q/op_b_q/ctrl_q; id_q=winner.
  - grant_out[winner]=1 for exactly one cycle; rr_ptr=(winner+1) mod NUM_REQ.
  - state→EXEC; busy_out=1.
- EXEC, at the next edge:
  - result_out = alu(op_a_q, op_b_q, ctrl_q).
  - result_id_out=id_q; result_valid_out=1 for one cycle.
  - op_err_out=(ctrl_q>4); busy_out=0; state→IDLE.
- Latency: request sampled at edge k → grant high during cycle k..k+1 → result valid during cycle k+1..k+2.
- Throughput: one operation per 2 cycles.
- Requester handshake:
  - Hold req and operands stable until grant is sampled high, then deassert req at that same edge.
  - If req stays high, the arbiter treats it as a new request.
- Re-arbitration happens in the IDLE cycle in which result_valid_out is high, so back-to-back grants are 2 cycles apart.
- result_out and result_id_out hold their last value when result_valid_out is low.
- Opcodes:
  - 0=add, 1=sub, 2=and, 3=or, 4=xor; 5..15 produce result 0 with op_err_out=1.
  - Add/sub wrap modulo 2**DATAPATH_WIDTH; there is no carry or overflow output.
- Changes to req_in or operands during EXEC are ignored; they are not latched until the next IDLE.
- A requester dropping req before grant loses its request; no state is kept.
- Reset mid-EXEC: the in-flight operation is discarded, no result_valid_out is produced, and rr_ptr returns to 0.
- Fairness: with all requesters held high, grants rotate 0,1,2,3,0,…; no requester waits more than NUM_REQ grants.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_OP_MAX=4.
  - FSM state encoding IDLE=1'b0, EXEC=1'b1.
- Natural sub-module: rr_arbiter (NUM_REQ), combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and encoded index.
- The existing alu module is instantiated as-is on the latched operands.

Test Plan:
- Single request: req_in=4'b0010, a=5, b=3, ctrl=1 → grant_out=0010 one cycle later; next cycle result_valid_out=1, result_out=2, result_id_out=1, op_err_out=0.
- Round-robin: all req held high, ctrl=0, a=i, b=10 → grant order 0,1,2,3,0; result_id_out matches; result_out=10..13; grants exactly 2 cycles apart.
- Wrap arithmetic: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, ctrl=0 → result_out=0; a=0, b=1, ctrl=1 → result_out=all ones.
- Illegal opcode: ctrl=4'd9, a=7, b=7 → result_out=0, op_err_out=1 coincident with result_valid_out.
- Reset mid-EXEC: assert reset while busy_out=1 → outputs go 0 immediately, no result_valid_out; after release, req_in=4'b1000 is granted to index 3 with rr_ptr starting at 0.
- Stable-in-EXEC: change a_in/ctrl_in of the winner during EXEC → result reflects the values latched at grant (e.g. latched and 0xF0 & 0x3C = 0x30).
